// File: rtl/branch_target_predictor.sv
// Branch target buffer with per-entry saturating direction counters for the IF stage.
// Optional statistics counters are built when BP_STATS_EN is defined.
module branch_target_predictor #(
    parameter int ENTRIES = 16,
    parameter int PC_W    = 32,
    parameter int CTR_W   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_pc,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_uncond,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [PC_W-1:0] upd_pred_pc,
    output logic            mispredict,
    output logic [PC_W-1:0] correct_pc,
    input  logic            flush_all,
    output logic [31:0]     stat_updates,
    output logic [31:0]     stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_RST  = CTR_WEAK - CTR_W'(1);

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [PC_W-1:0]  target_q [ENTRIES];
    logic [CTR_W-1:0] ctr_q    [ENTRIES];

    logic [IDX_W-1:0] lookupIdx, updIdx;
    logic [TAG_W-1:0] lookupTag, updTag;
    logic             updHit;
    logic             wrEn;
    logic [CTR_W-1:0] ctr_d;
    logic [PC_W-1:0]  target_d;

    assign lookupIdx  = if_pc[IDX_W+1:2];
    assign lookupTag  = if_pc[PC_W-1:IDX_W+2];
    assign updIdx     = upd_pc[IDX_W+1:2];
    assign updTag     = upd_pc[PC_W-1:IDX_W+2];

    assign pred_hit   = valid_q[lookupIdx] && (tag_q[lookupIdx] == lookupTag);
    assign pred_taken = pred_hit && ctr_q[lookupIdx][CTR_W-1];
    assign pred_pc    = pred_taken ? target_q[lookupIdx] : if_pc + PC_W'(4);

    assign mispredict = upd_valid && (upd_taken ? (upd_pred_pc != upd_target) : upd_pred_taken);
    assign correct_pc = (upd_valid && upd_taken) ? upd_target : upd_pc + PC_W'(4);

    assign updHit     = valid_q[updIdx] && (tag_q[updIdx] == updTag);

    // Next contents of the indexed entry; a miss that resolves not-taken leaves it alone.
    always_comb begin
        wrEn     = 1'b0;
        ctr_d    = ctr_q[updIdx];
        target_d = target_q[updIdx];
        if (upd_valid) begin
            if (updHit && upd_uncond) begin
                wrEn     = 1'b1;
                ctr_d    = CTR_MAX;
                target_d = upd_target;
            end else if (updHit) begin
                wrEn = 1'b1;
                if (upd_taken) begin
                    target_d = upd_target;
                    if (ctr_q[updIdx] != CTR_MAX) ctr_d = ctr_q[updIdx] + CTR_W'(1);
                end else if (ctr_q[updIdx] != '0) begin
                    ctr_d = ctr_q[updIdx] - CTR_W'(1);
                end
            end else if (upd_taken) begin
                wrEn     = 1'b1;
                ctr_d    = upd_uncond ? CTR_MAX : CTR_WEAK;
                target_d = upd_target;
            end
        end
    end

    // Flush wins over a same-cycle update so a stale redirect cannot repopulate the table.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RST;
            end
        end else if (flush_all) begin
            for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
        end else if (wrEn) begin
            valid_q[updIdx]  <= 1'b1;
            tag_q[updIdx]    <= updTag;
            target_q[updIdx] <= target_d;
            ctr_q[updIdx]    <= ctr_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] statUpd_q, statMis_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            statUpd_q <= '0;
            statMis_q <= '0;
        end else begin
            if (upd_valid && !flush_all && (statUpd_q != '1)) statUpd_q <= statUpd_q + 32'd1;
            if (mispredict && (statMis_q != '1)) statMis_q <= statMis_q + 32'd1;
        end
    end

    assign stat_updates     = statUpd_q;
    assign stat_mispredicts = statMis_q;
`else
    assign stat_updates     = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor: directed steps then random traffic
// checked against a table model indexed with plain arithmetic.
module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_pc;
    logic        upd_valid, upd_uncond, upd_taken, upd_pred_taken, flush_all;
    logic [31:0] upd_pc, upd_target, upd_pred_pc;
    logic        mispredict;
    logic [31:0] correct_pc;
    logic [31:0] stat_updates, stat_mispredicts;

    int passCount  = 0;
    int checkCount = 0;

    bit          mValid  [16];
    logic [31:0] mTag    [16];
    logic [31:0] mTarget [16];
    int          mCtr    [16];
    int unsigned mStatUpd, mStatMis;

    branch_target_predictor dut (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_pc(pred_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_uncond(upd_uncond),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_pc(upd_pred_pc),
        .mispredict(mispredict), .correct_pc(correct_pc), .flush_all(flush_all),
        .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    // Hard time limit so the bench always ends even if the clocking stalls.
    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount = checkCount + 1;
        assert (obs === exp) passCount = passCount + 1;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int idxOf(input logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    function automatic bit mHit(input logic [31:0] pc);
        return mValid[idxOf(pc)] && (mTag[idxOf(pc)] == (pc >> 6));
    endfunction

    function automatic bit mTaken(input logic [31:0] pc);
        return mHit(pc) && (mCtr[idxOf(pc)] >= 2);
    endfunction

    function automatic logic [31:0] mPredPc(input logic [31:0] pc);
        return mTaken(pc) ? mTarget[idxOf(pc)] : pc + 32'd4;
    endfunction

    function automatic bit mMis();
        if (!upd_valid) return 1'b0;
        return upd_taken ? (upd_pred_pc != upd_target) : upd_pred_taken;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 16; i++) begin
            mValid[i]  = 1'b0;
            mTag[i]    = '0;
            mTarget[i] = '0;
            mCtr[i]    = 1;
        end
        mStatUpd = 0;
        mStatMis = 0;
    endtask

    task automatic modelTrain();
        int i;
        if (mMis()) mStatMis = mStatMis + 1;
        if (flush_all) begin
            for (int k = 0; k < 16; k++) mValid[k] = 1'b0;
            return;
        end
        if (!upd_valid) return;
        mStatUpd = mStatUpd + 1;
        i = idxOf(upd_pc);
        if (mHit(upd_pc)) begin
            if (upd_uncond) begin
                mCtr[i] = 3;
                mTarget[i] = upd_target;
            end else if (upd_taken) begin
                mCtr[i] = (mCtr[i] < 3) ? mCtr[i] + 1 : 3;
                mTarget[i] = upd_target;
            end else begin
                mCtr[i] = (mCtr[i] > 0) ? mCtr[i] - 1 : 0;
            end
        end else if (upd_taken) begin
            mValid[i]  = 1'b1;
            mTag[i]    = upd_pc >> 6;
            mTarget[i] = upd_target;
            mCtr[i]    = upd_uncond ? 3 : 2;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                                 input logic unc, input logic tk, input logic [31:0] tgt,
                                 input logic ptk, input logic [31:0] ppc, input logic fl);
        if_pc = lpc; upd_valid = uv; upd_pc = upc; upd_uncond = unc; upd_taken = tk;
        upd_target = tgt; upd_pred_taken = ptk; upd_pred_pc = ppc; flush_all = fl;
    endtask

    // Called at a falling edge with inputs applied; compares against the model mid low phase.
    task automatic lookCheck();
        #2;
        checkOutput("pred_hit", 32'(pred_hit), 32'(mHit(if_pc)));
        checkOutput("pred_taken", 32'(pred_taken), 32'(mTaken(if_pc)));
        checkOutput("pred_pc", pred_pc, mPredPc(if_pc));
        checkOutput("mispredict", 32'(mispredict), 32'(mMis()));
        if (upd_valid) checkOutput("correct_pc", correct_pc, upd_taken ? upd_target : upd_pc + 32'd4);
`ifdef BP_STATS_EN
        checkOutput("stat_updates", stat_updates, mStatUpd);
        checkOutput("stat_mispredicts", stat_mispredicts, mStatMis);
`else
        checkOutput("stat_updates_tied", stat_updates, 32'd0);
        checkOutput("stat_mispredicts_tied", stat_mispredicts, 32'd0);
`endif
    endtask

    task automatic endCycle();
        @(posedge clk);
        modelTrain();
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] lpc);
        applyStimulus(lpc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    localparam logic [31:0] PA = 32'h0040_0010;
    localparam logic [31:0] PB = 32'h0040_0050;
    localparam logic [31:0] TA = 32'h0040_0100;

    initial begin
        logic [31:0] rpc;
        logic        rtk, runc;
        rst = 1'b0;
        modelReset();
        idle(PA);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        $display("[TB] reset state lookup");
        lookCheck();
        checkOutput("rst_hit", 32'(pred_hit), 32'd0);
        checkOutput("rst_pc", pred_pc, 32'h0040_0014);
        endCycle();

        $display("[TB] first taken update allocates");
        applyStimulus(PA, 1'b1, PA, 1'b0, 1'b1, TA, 1'b0, PA + 32'd4, 1'b0);
        lookCheck();
        checkOutput("alloc_mis", 32'(mispredict), 32'd1);
        checkOutput("alloc_cpc", correct_pc, TA);
        checkOutput("no_bypass_hit", 32'(pred_hit), 32'd0);
        endCycle();
        idle(PA);
        lookCheck();
        checkOutput("alloc_hit", 32'(pred_hit), 32'd1);
        checkOutput("alloc_pc", pred_pc, TA);
        endCycle();

        $display("[TB] counter decay and saturation");
        applyStimulus(PA, 1'b1, PA, 1'b0, 1'b0, TA, 1'b1, TA, 1'b0);
        lookCheck();
        checkOutput("nt_cpc", correct_pc, 32'h0040_0014);
        endCycle();
        idle(PA);
        lookCheck();
        checkOutput("ctr1_pc", pred_pc, 32'h0040_0014);
        endCycle();
        for (int n = 0; n < 2; n++) begin
            applyStimulus(PA, 1'b1, PA, 1'b0, 1'b0, TA, 1'b0, PA + 32'd4, 1'b0);
            lookCheck();
            endCycle();
        end
        applyStimulus(PA, 1'b1, PA, 1'b0, 1'b1, TA, 1'b0, PA + 32'd4, 1'b0);
        lookCheck();
        endCycle();
        idle(PA);
        lookCheck();
        checkOutput("ctr1_again_taken", 32'(pred_taken), 32'd0);
        endCycle();
        applyStimulus(PA, 1'b1, PA, 1'b0, 1'b1, TA, 1'b0, PA + 32'd4, 1'b0);
        lookCheck();
        endCycle();
        idle(PA);
        lookCheck();
        checkOutput("restored_taken", 32'(pred_taken), 32'd1);
        checkOutput("restored_pc", pred_pc, TA);
        endCycle();

        $display("[TB] aliasing eviction");
        applyStimulus(PA, 1'b1, PB, 1'b0, 1'b1, 32'h0040_0200, 1'b0, PB + 32'd4, 1'b0);
        lookCheck();
        endCycle();
        idle(PA);
        lookCheck();
        checkOutput("alias_evict_hit", 32'(pred_hit), 32'd0);
        endCycle();
        idle(PB);
        lookCheck();
        checkOutput("alias_new_pc", pred_pc, 32'h0040_0200);
        endCycle();

        $display("[TB] flush with same-cycle update");
        applyStimulus(PB, 1'b1, 32'h0040_0080, 1'b1, 1'b1, 32'h0040_0300, 1'b0, 32'h0, 1'b1);
        lookCheck();
        endCycle();
        idle(PB);
        lookCheck();
        checkOutput("flush_old_hit", 32'(pred_hit), 32'd0);
        endCycle();
        idle(32'h0040_0080);
        lookCheck();
        checkOutput("flush_discard_hit", 32'(pred_hit), 32'd0);
        endCycle();

        $display("[TB] asynchronous reset mid-training");
        for (int n = 0; n < 8; n++) begin
            applyStimulus(32'h0040_0000, 1'b1, 32'h0040_0000 + 32'(n * 4), 1'b0, 1'b1,
                          32'h0050_0000 + 32'(n * 16), 1'b0, 32'h0, 1'b0);
            lookCheck();
            endCycle();
        end
        applyStimulus(32'h0040_0000, 1'b1, 32'h0040_0020, 1'b1, 1'b1, 32'h0060_0000, 1'b0, 32'h0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        checkOutput("async_rst_hit", 32'(pred_hit), 32'd0);
        checkOutput("async_rst_pc", pred_pc, 32'h0040_0004);
`ifdef BP_STATS_EN
        checkOutput("async_rst_stat_upd", stat_updates, 32'd0);
        checkOutput("async_rst_stat_mis", stat_mispredicts, 32'd0);
`endif
        @(negedge clk);
        idle(32'h0040_0000);
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 5; n++) begin
            rpc = 32'h0040_1000 + 32'(n * 4);
            if (n < 2) applyStimulus(rpc, 1'b1, rpc, 1'b0, 1'b1, 32'h0070_0000, 1'b0, rpc + 32'd4, 1'b0);
            else       applyStimulus(rpc, 1'b1, rpc, 1'b0, 1'b0, 32'h0, 1'b0, rpc + 32'd4, 1'b0);
            lookCheck();
            endCycle();
        end
        idle(32'h0040_1000);
        lookCheck();
`ifdef BP_STATS_EN
        checkOutput("stats_upd_5", stat_updates, 32'd5);
        checkOutput("stats_mis_2", stat_mispredicts, 32'd2);
`endif
        endCycle();

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            rpc  = 32'h0040_0000 | (32'($urandom_range(0, 63)) << 2);
            runc = ($urandom_range(0, 3) == 0);
            rtk  = runc ? 1'b1 : 1'($urandom_range(0, 1));
            applyStimulus(32'h0040_0000 | (32'($urandom_range(0, 63)) << 2),
                          1'($urandom_range(0, 2) != 0), rpc, runc, rtk,
                          32'h0040_0000 | (32'($urandom_range(0, 1023)) << 2),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 1) == 0) ? rpc + 32'd4 : mTarget[idxOf(rpc)],
                          ($urandom_range(0, 29) == 0));
            lookCheck();
            endCycle();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
